bus_arbiter: RTL and testbench

- N-master round-robin arbiter for the pipelined wishbone-style shared bus.
- Sits upstream of the bus interconnect's master port; multiplexes one granted requester onto it.
- Grant is held for a whole cycle (cyc) burst; ack/err/data are routed back only to the owner.
- Tracks outstanding pipelined transfers so ownership, and any optional watchdog, is exact.

---
 rtl/bus_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter multiplexing one of numMasters pipelined wishbone-style masters onto a shared bus.
// Optional ownership watchdog is compiled in when BUS_ARB_TIMEOUT_EN is defined.
`ifndef BUS_DATAWIDTH
`define BUS_DATAWIDTH 32
`endif

module bus_arbiter #(
  parameter int numMasters = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = `BUS_DATAWIDTH,
  parameter int MAX_OUTST  = 15,
  parameter int TIMEOUT    = 255,
  localparam int SEL_W     = DATA_W / 8,
  localparam int OW        = $clog2(MAX_OUTST + 1),
  localparam int IW        = $clog2(numMasters)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [numMasters-1:0]        m_cyc,
  input  logic [numMasters-1:0]        m_stb,
  input  logic [numMasters-1:0]        m_we,
  input  logic [numMasters*ADDR_W-1:0] m_addr,
  input  logic [numMasters*SEL_W-1:0]  m_sel,
  input  logic [numMasters*DATA_W-1:0] m_data_m2s,
  output logic [DATA_W-1:0]            m_data_s2m,
  output logic [numMasters-1:0]        m_ack,
  output logic [numMasters-1:0]        m_err,
  output logic [numMasters-1:0]        m_stall,
  output logic                         s_cyc,
  output logic                         s_stb,
  output logic                         s_we,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [SEL_W-1:0]             s_sel,
  output logic [DATA_W-1:0]            s_data_m2s,
  input  logic [DATA_W-1:0]            s_data_s2m,
  input  logic                         s_ack,
  input  logic                         s_err,
  input  logic                         s_stall,
  output logic [numMasters-1:0]        grant,
  output logic [OW-1:0]                outst
);

  if (numMasters < 2 || numMasters > 8 || MAX_OUTST < 1 || TIMEOUT < 1) begin : g_param_check
    $error("bus_arbiter: parameter out of range");
  end

  typedef enum logic [0:0] {IDLE = 1'b0, OWN = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [numMasters-1:0]   grant_q, grant_d;
  logic [IW-1:0]           last_q, last_d;
  logic [OW-1:0]           outst_q, outst_d;
  logic [IW-1:0]           next_s;
  logic                    next_vld_s;
  logic                    own_cyc_s, cap_s, resp_ok_s, acc_s, rsp_s;
  logic                    hold_s, wd_fire_s;

  function automatic logic [numMasters-1:0] onehot(input logic [IW-1:0] idx);
    logic [numMasters-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // last_q always names the current (or most recent) owner, so it doubles as the owner index
  assign own_cyc_s  = (state_q == OWN) & m_cyc[last_q];
  assign cap_s      = (outst_q == OW'(MAX_OUTST));
  assign resp_ok_s  = own_cyc_s & ~hold_s & (outst_q != '0);
  assign acc_s      = s_stb & ~s_stall;
  assign rsp_s      = (s_ack | s_err) & (outst_q != '0);
  assign grant      = grant_q;
  assign outst      = outst_q;
  assign m_data_s2m = s_data_s2m;

  // Round-robin search starting just after the last owner, wrapping, last owner checked last
  always_comb begin : rr_search
    logic [IW:0] sum;
    next_s     = last_q;
    next_vld_s = 1'b0;
    sum        = '0;
    for (int k = 1; k <= numMasters; k++) begin
      sum = {1'b0, last_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(numMasters)) begin
        sum = sum - (IW+1)'(numMasters);
      end else begin
        sum = sum;
      end
      if (!next_vld_s && m_cyc[sum[IW-1:0]]) begin
        next_vld_s = 1'b1;
        next_s     = sum[IW-1:0];
      end else begin
        next_vld_s = next_vld_s;
      end
    end
  end

  // Forward the owner's request to the interconnect and route responses back to it only
  always_comb begin
    s_cyc      = 1'b0;
    s_stb      = 1'b0;
    s_we       = 1'b0;
    s_addr     = '0;
    s_sel      = '0;
    s_data_m2s = '0;
    m_ack      = '0;
    m_err      = '0;
    m_stall    = '1;
    if (state_q == OWN) begin
      s_cyc           = own_cyc_s & ~hold_s;
      s_stb           = own_cyc_s & m_stb[last_q] & ~cap_s & ~hold_s;
      s_we            = m_we[last_q];
      s_addr          = m_addr[int'(last_q)*ADDR_W +: ADDR_W];
      s_sel           = m_sel[int'(last_q)*SEL_W +: SEL_W];
      s_data_m2s      = m_data_m2s[int'(last_q)*DATA_W +: DATA_W];
      m_stall[last_q] = s_stall | cap_s | hold_s;
      m_ack[last_q]   = s_ack & resp_ok_s;
      m_err[last_q]   = (s_err & resp_ok_s) | wd_fire_s;
    end else begin
      m_stall = '1;
    end
  end

  // Ownership FSM and outstanding-transfer counter next state
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    outst_d = outst_q;
    case (state_q)
      IDLE: begin
        if (next_vld_s) begin
          state_d = OWN;
          grant_d = onehot(next_s);
          last_d  = next_s;
        end else begin
          grant_d = '0;
        end
      end
      OWN: begin
        if (!own_cyc_s) begin
          outst_d = '0;
          if (next_vld_s) begin
            grant_d = onehot(next_s);
            last_d  = next_s;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (wd_fire_s) begin
          outst_d = '0;
        end else if (acc_s && !rsp_s) begin
          outst_d = outst_q + OW'(1);
        end else if (!acc_s && rsp_s) begin
          outst_d = outst_q - OW'(1);
        end else begin
          outst_d = outst_q;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        outst_d = '0;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(numMasters - 1);
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      outst_q <= outst_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          hold_q, hold_d;

  assign hold_s    = hold_q;
  assign wd_fire_s = own_cyc_s & ~hold_q & (outst_q != '0) & ~s_ack & ~s_err
                     & (wd_q == WW'(TIMEOUT - 1));

  // Watchdog: count silent cycles with transfers pending; after firing, keep the bus off until release
  always_comb begin
    wd_d   = wd_q;
    hold_d = hold_q;
    if (!own_cyc_s) begin
      wd_d   = '0;
      hold_d = 1'b0;
    end else if (wd_fire_s) begin
      wd_d   = '0;
      hold_d = 1'b1;
    end else if (s_ack || s_err || outst_q == '0) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + WW'(1);
    end
  end

  // Watchdog registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q   <= '0;
      hold_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      hold_q <= hold_d;
    end
  end
`else
  assign hold_s    = 1'b0;
  assign wd_fire_s = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: scripted masters, a latency-programmable slave model and a read-data scoreboard.
// Define BUS_ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT=8).
module tb_bus_arbiter;
  localparam int NM = 2, AW = 32, DW = 32, SW = 4, OWB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [NM-1:0] m_cyc, m_stb, m_we, m_ack, m_err, m_stall, grant;
  logic [NM*AW-1:0] m_addr;
  logic [NM*SW-1:0] m_sel;
  logic [NM*DW-1:0] m_data_m2s;
  logic [DW-1:0] m_data_s2m, s_data_m2s, s_data_s2m;
  logic s_cyc, s_stb, s_we, s_ack, s_err, s_stall;
  logic [AW-1:0] s_addr;
  logic [SW-1:0] s_sel;
  logic [OWB-1:0] outst;

  bus_arbiter #(.numMasters(NM), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(15), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr),
    .m_sel(m_sel), .m_data_m2s(m_data_m2s), .m_data_s2m(m_data_s2m), .m_ack(m_ack),
    .m_err(m_err), .m_stall(m_stall), .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
    .s_addr(s_addr), .s_sel(s_sel), .s_data_m2s(s_data_m2s), .s_data_s2m(s_data_s2m),
    .s_ack(s_ack), .s_err(s_err), .s_stall(s_stall), .grant(grant), .outst(outst)
  );

  int n_checks = 0, n_pass = 0;
  int cyc_n = 0, slv_lat = 1, outst_max = 0, stall_viol = 0;
  bit slv_mute = 1'b0;
  int ack_cnt[NM], err_cnt[NM];
  logic [31:0] sb_q[$];
  logic [31:0] pend_addr[$];
  int pend_due[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Observe the bus at the falling edge: slave accepts, owner responses, non-owner stall
  task automatic monitor();
    if (s_cyc && s_stb && !s_stall) begin
      pend_addr.push_back(s_addr);
      pend_due.push_back(cyc_n + slv_lat);
    end
    for (int i = 0; i < NM; i++) begin
      if (m_ack[i]) begin
        ack_cnt[i]++;
        if (sb_q.size() > 0) check_eq("rdata", m_data_s2m, sb_q.pop_front());
        else check_eq("spurious_ack", 32'(m_ack), 32'd0);
      end
      if (m_err[i]) err_cnt[i]++;
      if (!grant[i] && !m_stall[i]) stall_viol++;
    end
    if (int'(outst) > outst_max) outst_max = int'(outst);
  endtask

  // One clock: monitor, then just after the rising edge drive the slave response
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc_n++;
    s_ack = 1'b0;
    s_err = 1'b0;
    s_data_s2m = '0;
    if (!slv_mute && pend_due.size() > 0 && pend_due[0] <= cyc_n) begin
      s_ack = 1'b1;
      s_data_s2m = ~pend_addr[0];
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0; m_addr = '0; m_data_m2s = '0;
    tick();
    tick();
    rst = 1'b0;
    sb_q.delete(); pend_addr.delete(); pend_due.delete();
    s_ack = 1'b0; slv_mute = 1'b0;
  endtask

  task automatic wait_grant(input int i, input string tag);
    int n = 0;
    while (grant[i] !== 1'b1 && n < 20) begin tick(); n++; end
    check_eq(tag, 32'(grant), 32'd1 << i);
  endtask

  task automatic burst(input int i, input int n, input logic [31:0] base);
    int sent = 0, guard = 0, a0 = ack_cnt[i];
    m_cyc[i] = 1'b1;
    wait_grant(i, "burst_grant");
    while (sent < n && guard < 200) begin
      m_stb[i] = 1'b1;
      m_addr[i*AW +: AW] = base + 32'(sent * 4);
      #1;
      if (!m_stall[i]) begin sb_q.push_back(~(base + 32'(sent * 4))); sent++; end
      tick(); guard++;
    end
    m_stb[i] = 1'b0;
    guard = 0;
    while (ack_cnt[i] - a0 < n && guard < 100) begin tick(); guard++; end
    check_eq("burst_acks", 32'(ack_cnt[i] - a0), 32'(n));
    #1 check_eq("burst_outst0", 32'(outst), 32'd0);
    m_cyc[i] = 1'b0;
    tick();
  endtask

  initial begin
    int sent, a0, t_acc, t_err, guard, e0;
    rst = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0; m_addr = '0; m_sel = '1; m_data_m2s = '0;
    s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0; s_data_s2m = '0;
    for (int i = 0; i < NM; i++) begin ack_cnt[i] = 0; err_cnt[i] = 0; end

    // reset state
    do_reset();
    #1;
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_outst", 32'(outst), 32'd0);
    check_eq("rst_s_cyc", 32'({s_cyc, s_stb, s_we}), 32'd0);
    check_eq("rst_s_addr", s_addr, 32'd0);
    check_eq("rst_m_stall", 32'(m_stall), 32'd3);
    check_eq("rst_m_ackerr", 32'({m_ack, m_err}), 32'd0);

    // single read by master 0, ack after 2 cycles
    slv_lat = 2;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_addr[0 +: AW] = 32'h2152_4110;
    #1 check_eq("t1_grant_lat", 32'(grant), 32'd0);
    tick();
    #1 check_eq("t1_grant", 32'(grant), 32'd1);
    check_eq("t1_s_stb", 32'(s_stb), 32'd1);
    check_eq("t1_stall1", 32'(m_stall[1]), 32'd1);
    sb_q.push_back(32'hDEAD_BEEF);
    tick();
    m_stb[0] = 1'b0;
    #1 check_eq("t1_outst1", 32'(outst), 32'd1);
    tick();
    #1 check_eq("t1_ack", 32'(m_ack), 32'd1);
    check_eq("t1_data", m_data_s2m, 32'hDEAD_BEEF);
    tick();
    #1 check_eq("t1_outst0", 32'(outst), 32'd0);
    m_cyc[0] = 1'b0;
    #1 check_eq("t1_cyc_drop", 32'(s_cyc), 32'd0);
    tick();
    #1 check_eq("t1_idle", 32'(grant), 32'd0);

    // simultaneous requests: master 0 first, then direct handover to master 1
    do_reset();
    slv_lat = 1;
    m_cyc = 2'b11;
    tick();
    #1 check_eq("t2_first", 32'(grant), 32'd1);
    tick();
    m_cyc[0] = 1'b0;
    #1 check_eq("t2_cyc_drop", 32'(s_cyc), 32'd0);
    tick();
    #1 check_eq("t2_handover", 32'(grant), 32'd2);
    check_eq("t2_s_cyc", 32'(s_cyc), 32'd1);
    burst(1, 1, 32'h0000_1000);

    // pipelined burst of 4, acks delayed 3 cycles
    do_reset();
    slv_lat = 3;
    outst_max = 0;
    a0 = ack_cnt[0];
    burst(0, 4, 32'h0000_2000);
    check_eq("t3_peak", 32'(outst_max >= 3 && outst_max <= 4), 32'd1);
    check_eq("t3_acks", 32'(ack_cnt[0] - a0), 32'd4);

    // outstanding cap at 15: 16th strobe held until first ack
    do_reset();
    slv_lat = 1; slv_mute = 1'b1;
    m_cyc[0] = 1'b1;
    wait_grant(0, "t4_grant");
    sent = 0;
    for (int k = 0; k < 15; k++) begin
      m_stb[0] = 1'b1; m_addr[0 +: AW] = 32'h0000_3000 + 32'(sent * 4);
      #1;
      if (!m_stall[0]) begin sb_q.push_back(~(32'h0000_3000 + 32'(sent * 4))); sent++; end
      tick();
    end
    check_eq("t4_accepts", 32'(sent), 32'd15);
    m_addr[0 +: AW] = 32'h0000_3000 + 32'(sent * 4);
    #1 check_eq("t4_outst_cap", 32'(outst), 32'd15);
    check_eq("t4_stall_cap", 32'(m_stall[0]), 32'd1);
    check_eq("t4_stb_cap", 32'(s_stb), 32'd0);
    slv_mute = 1'b0;
    tick();
    #1 check_eq("t4_stall_ackcyc", 32'(m_stall[0]), 32'd1);
    tick();
    #1 check_eq("t4_released", 32'({s_stb, m_stall[0]}), 32'd2);
    sb_q.push_back(~(32'h0000_3000 + 32'(sent * 4)));
    tick();
    m_stb[0] = 1'b0;
    guard = 0;
    while (sb_q.size() > 0 && guard < 60) begin tick(); guard++; end
    check_eq("t4_drain", 32'(sb_q.size()), 32'd0);
    m_cyc[0] = 1'b0;
    tick();

    // reset with two transfers in flight; late acks must be dropped
    do_reset();
    slv_lat = 1; slv_mute = 1'b1;
    m_cyc[0] = 1'b1;
    wait_grant(0, "t5_grant");
    m_stb[0] = 1'b1;
    tick();
    tick();
    m_stb[0] = 1'b0;
    #1 check_eq("t5_outst2", 32'(outst), 32'd2);
    rst = 1'b1; m_cyc = '0;
    tick();
    rst = 1'b0;
    #1 check_eq("t5_grant", 32'(grant), 32'd0);
    check_eq("t5_outst", 32'(outst), 32'd0);
    check_eq("t5_s_cyc", 32'(s_cyc), 32'd0);
    sb_q.delete();
    slv_mute = 1'b0;
    a0 = ack_cnt[0] + ack_cnt[1];
    repeat (6) tick();
    check_eq("t5_no_late_ack", 32'(ack_cnt[0] + ack_cnt[1] - a0), 32'd0);

`ifdef BUS_ARB_TIMEOUT_EN
    // watchdog: slave never answers
    do_reset();
    slv_mute = 1'b1;
    m_cyc[0] = 1'b1;
    wait_grant(0, "t6_grant");
    m_stb[0] = 1'b1; m_addr[0 +: AW] = 32'h0000_4000;
    #1 check_eq("t6_accept", 32'(m_stall[0]), 32'd0);
    t_acc = cyc_n;
    tick();
    m_stb[0] = 1'b0; m_cyc[1] = 1'b1;
    e0 = err_cnt[0]; t_err = -1; guard = 0;
    while (t_err < 0 && guard < 40) begin
      #1;
      if (m_err[0]) t_err = cyc_n;
      tick(); guard++;
    end
    check_eq("t6_latency", 32'(t_err - t_acc), 32'd8);
    #1 check_eq("t6_s_cyc_off", 32'(s_cyc), 32'd0);
    check_eq("t6_still_owner", 32'(grant), 32'd1);
    tick();
    #1 check_eq("t6_single_err", 32'(err_cnt[0] - e0), 32'd1);
    check_eq("t6_outst0", 32'(outst), 32'd0);
    m_cyc[0] = 1'b0;
    tick();
    #1 check_eq("t6_next_owner", 32'(grant), 32'd2);
    m_cyc[1] = 1'b0;
    tick();
`endif

    check_eq("nonowner_stall", 32'(stall_viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
